// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the interrupt aggregator.
package irq_ctrl_pkg;

    localparam int NUM_IRQ_DEFAULT = 4;
    localparam int GAP_CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_edge_detect.sv
// Per-line rising-edge detector: registers the previous level of every line
// and flags lines that are high now but were low in the previous cycle.
// History clears to zero so a line already high at reset release is
// reported as an edge on the first clock.
module irq_edge_detect #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] hist_r;

    // Capture the previous-cycle level of each line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_r <= {WIDTH{1'b0}};
        end else begin
            hist_r <= level;
        end
    end

    assign rise = level & ~hist_r;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches rising edges of NUM_IRQ level sources into
// pending bits, clears them through a valid/ready write-1-to-clear ack, and
// drives one registered irq_o through an IDLE/ASSERT/GAP FSM that enforces a
// minimum low time of GAP_CYCLES between assertions.
// Optional feature macro: IRQ_CTRL_OVERFLOW_EN adds the sticky overflow_o
// flags (edge seen on an already-pending source).
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_IRQ    = NUM_IRQ_DEFAULT,
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] enable_i,
    input  logic               ack_valid_i,
    input  logic [NUM_IRQ-1:0] ack_mask_i,
    output logic               ack_ready_o,
    output logic [NUM_IRQ-1:0] pending_o,
`ifdef IRQ_CTRL_OVERFLOW_EN
    output logic               irq_o,
    output logic [NUM_IRQ-1:0] overflow_o
`else
    output logic               irq_o
`endif
);

    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_CYCLES - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_ONE  = GAP_CNT_W'(1);
    localparam logic [GAP_CNT_W-1:0] GAP_ZERO = GAP_CNT_W'(0);

    logic [NUM_IRQ-1:0]   rise_s;
    logic [NUM_IRQ-1:0]   clr_s;
    logic [NUM_IRQ-1:0]   pending_r;
    logic                 active_s;
    logic                 ack_fire_s;
    irq_state_t           state_r;
    logic [GAP_CNT_W-1:0] gap_cnt_r;
    logic                 irq_r;
    logic                 ack_ready_r;

    irq_edge_detect #(
        .WIDTH (NUM_IRQ)
    ) u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (irq_i),
        .rise  (rise_s)
    );

    assign ack_fire_s = ack_valid_i & ack_ready_r;
    assign active_s   = |(pending_r & enable_i);

    // Clear mask is the ack mask only on an accepted handshake.
    always_comb begin
        clr_s = {NUM_IRQ{1'b0}};
        if (ack_fire_s) begin
            clr_s = ack_mask_i;
        end else begin
            clr_s = {NUM_IRQ{1'b0}};
        end
    end

    // Pending bits: a fresh edge wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= {NUM_IRQ{1'b0}};
        end else begin
            pending_r <= rise_s | (pending_r & ~clr_s);
        end
    end

    // Assertion FSM with registered irq and ack-ready outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            gap_cnt_r   <= GAP_ZERO;
            irq_r       <= 1'b0;
            ack_ready_r <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    gap_cnt_r   <= GAP_ZERO;
                    ack_ready_r <= 1'b1;
                    if (active_s) begin
                        state_r <= ASSERT;
                        irq_r   <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        irq_r   <= 1'b0;
                    end
                end
                ASSERT: begin
                    if (!active_s) begin
                        state_r     <= GAP;
                        gap_cnt_r   <= GAP_LOAD;
                        irq_r       <= 1'b0;
                        ack_ready_r <= 1'b0;
                    end else begin
                        state_r     <= ASSERT;
                        gap_cnt_r   <= GAP_ZERO;
                        irq_r       <= 1'b1;
                        ack_ready_r <= 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt_r == GAP_ZERO) begin
                        ack_ready_r <= 1'b1;
                        if (active_s) begin
                            state_r <= ASSERT;
                            irq_r   <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            irq_r   <= 1'b0;
                        end
                    end else begin
                        state_r     <= GAP;
                        gap_cnt_r   <= gap_cnt_r - GAP_ONE;
                        irq_r       <= 1'b0;
                        ack_ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    gap_cnt_r   <= GAP_ZERO;
                    irq_r       <= 1'b0;
                    ack_ready_r <= 1'b1;
                end
            endcase
        end
    end

`ifdef IRQ_CTRL_OVERFLOW_EN
    logic [NUM_IRQ-1:0] overflow_r;

    // Sticky overflow: edge on an already-pending bit not being cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= {NUM_IRQ{1'b0}};
        end else begin
            overflow_r <= (rise_s & pending_r & ~clr_s) | (overflow_r & ~clr_s);
        end
    end

    assign overflow_o = overflow_r;
`endif

    assign irq_o       = irq_r;
    assign ack_ready_o = ack_ready_r;
    assign pending_o   = pending_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: the driver applies inputs on the falling
// edge, advances a behavioural model and queues the expected post-edge
// outputs; a monitor pops and compares them after each rising edge.
module tb_irq_ctrl;

    localparam int N = 4;
    localparam int G = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] irq_i;
    logic [N-1:0] enable_i;
    logic         ack_valid_i;
    logic [N-1:0] ack_mask_i;
    logic         ack_ready_o;
    logic [N-1:0] pending_o;
    logic         irq_o;
`ifdef IRQ_CTRL_OVERFLOW_EN
    logic [N-1:0] overflow_o;
`endif

    irq_ctrl #(.NUM_IRQ(N), .GAP_CYCLES(G)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_i       (irq_i),
        .enable_i    (enable_i),
        .ack_valid_i (ack_valid_i),
        .ack_mask_i  (ack_mask_i),
        .ack_ready_o (ack_ready_o),
        .pending_o   (pending_o),
`ifdef IRQ_CTRL_OVERFLOW_EN
        .overflow_o  (overflow_o),
`endif
        .irq_o       (irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] pend;
        logic         irq;
        logic         rdy;
        logic [N-1:0] ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    // Reference model: per-source bits, irq level and remaining forced-low cycles.
    bit m_prev[N];
    bit m_pend[N];
    bit m_ovf[N];
    bit m_irq;
    int m_wait;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [N-1:0] pack(input bit v[N]);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = v[i];
        return r;
    endfunction

    function automatic bit model_ready();
        return !(!m_irq && m_wait > 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_prev[i] = 1'b0;
            m_pend[i] = 1'b0;
            m_ovf[i]  = 1'b0;
        end
        m_irq  = 1'b0;
        m_wait = 0;
    endtask

    // Drive inputs now, advance the model one clock and queue what the DUT should show.
    task automatic apply(input logic [N-1:0] iv, input logic [N-1:0] ev,
                         input logic av, input logic [N-1:0] am);
        bit   act;
        bit   rdy_now;
        bit   rise;
        bit   clr;
        exp_t e;
        irq_i       = iv;
        enable_i    = ev;
        ack_valid_i = av;
        ack_mask_i  = am;
        act = 1'b0;
        for (int i = 0; i < N; i++) if (m_pend[i] && ev[i]) act = 1'b1;
        rdy_now = model_ready();
        for (int i = 0; i < N; i++) begin
            rise = iv[i] && !m_prev[i];
            clr  = av && rdy_now && am[i];
            m_ovf[i]  = (rise && m_pend[i] && !clr) || (m_ovf[i] && !clr);
            m_pend[i] = rise || (m_pend[i] && !clr);
            m_prev[i] = iv[i];
        end
        if (m_irq) begin
            if (!act) begin
                m_irq  = 1'b0;
                m_wait = G;
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) m_irq = act;
        end else begin
            m_irq = act;
        end
        e.pend = pack(m_pend);
        e.irq  = m_irq;
        e.rdy  = model_ready();
        e.ovf  = pack(m_ovf);
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [N-1:0] iv, input logic [N-1:0] ev,
                        input logic av, input logic [N-1:0] am);
        @(negedge clk);
        apply(iv, ev, av, am);
    endtask

    // Monitor: compare queued expectations just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("pending_o", 32'(pending_o), 32'(mon_e.pend));
            check("irq_o", 32'(irq_o), 32'(mon_e.irq));
            check("ack_ready_o", 32'(ack_ready_o), 32'(mon_e.rdy));
`ifdef IRQ_CTRL_OVERFLOW_EN
            check("overflow_o", 32'(overflow_o), 32'(mon_e.ovf));
`endif
        end
    end

    initial begin
        logic [N-1:0] iv;
        logic [N-1:0] ev;
        model_reset();
        rst_n       = 1'b0;
        irq_i       = 4'b0000;
        enable_i    = 4'b0000;
        ack_valid_i = 1'b0;
        ack_mask_i  = 4'b0000;
        #12;
        check("reset pending_o", 32'(pending_o), 32'h0);
        check("reset irq_o", 32'(irq_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready after reset", 32'(ack_ready_o), 32'h1);
        apply(4'b0000, 4'b0001, 1'b0, 4'b0000);

        // Edge on source 0, enabled: pending next cycle, irq two cycles after.
        step(4'b0001, 4'b0001, 1'b0, 4'b0000);
        step(4'b0001, 4'b0001, 1'b0, 4'b0000);
        step(4'b0001, 4'b0001, 1'b0, 4'b0000);
        // Ack clears; held-high level must not re-set; GAP then IDLE.
        step(4'b0001, 4'b0001, 1'b1, 4'b0001);
        for (int k = 0; k < 5; k++) step(4'b0001, 4'b0001, 1'b1, 4'b0000);
        // Edge on source 2 coincides with its clear: set wins.
        step(4'b0000, 4'b1111, 1'b0, 4'b0000);
        step(4'b0100, 4'b1111, 1'b0, 4'b0000);
        step(4'b0100, 4'b1111, 1'b0, 4'b0000);
        step(4'b0000, 4'b1111, 1'b0, 4'b0000);
        step(4'b0100, 4'b1111, 1'b1, 4'b0100);
        step(4'b0100, 4'b1111, 1'b0, 4'b0000);
        // Clear everything, then an edge during GAP re-asserts after it.
        step(4'b0000, 4'b1111, 1'b1, 4'b1111);
        step(4'b0000, 4'b1111, 1'b0, 4'b0000);
        step(4'b0010, 4'b1111, 1'b0, 4'b0000);
        for (int k = 0; k < 4; k++) step(4'b0010, 4'b1111, 1'b0, 4'b0000);
        // Masked source: pending without irq until enabled.
        for (int k = 0; k < 4; k++) step(4'b0000, 4'b0000, 1'b1, 4'b1111);
        step(4'b0010, 4'b0000, 1'b0, 4'b0000);
        step(4'b0010, 4'b0000, 1'b0, 4'b0000);
        step(4'b0010, 4'b0000, 1'b0, 4'b0000);
        step(4'b0010, 4'b0010, 1'b0, 4'b0000);
        step(4'b0010, 4'b0010, 1'b0, 4'b0000);
        // Disabling while asserted behaves like an ack.
        step(4'b0010, 4'b0000, 1'b0, 4'b0000);
        for (int k = 0; k < 4; k++) step(4'b0010, 4'b0000, 1'b0, 4'b0000);
        // Two edges on source 3 without ack, then ack.
        step(4'b1000, 4'b1111, 1'b0, 4'b0000);
        step(4'b0000, 4'b1111, 1'b0, 4'b0000);
        step(4'b1000, 4'b1111, 1'b0, 4'b0000);
        step(4'b1000, 4'b1111, 1'b0, 4'b0000);
        step(4'b1000, 4'b1111, 1'b1, 4'b1010);
        for (int k = 0; k < 4; k++) step(4'b1000, 4'b1111, 1'b0, 4'b0000);

        // Async reset while asserted.
        step(4'b0000, 4'b1111, 1'b0, 4'b0000);
        step(4'b0001, 4'b1111, 1'b0, 4'b0000);
        step(4'b0001, 4'b1111, 1'b0, 4'b0000);
        step(4'b0001, 4'b1111, 1'b0, 4'b0000);
        @(posedge clk);
        #2;
        check("irq before reset", 32'(irq_o), 32'(m_irq));
        rst_n = 1'b0;
        #1;
        check("async reset irq_o", 32'(irq_o), 32'h0);
        check("async reset pending_o", 32'(pending_o), 32'h0);
        check("async reset ack_ready_o", 32'(ack_ready_o), 32'h1);
`ifdef IRQ_CTRL_OVERFLOW_EN
        check("async reset overflow_o", 32'(overflow_o), 32'h0);
`endif
        model_reset();
        // Source 3 held high across release registers as an edge.
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'b1000, 4'b1111, 1'b0, 4'b0000);
        for (int k = 0; k < 3; k++) step(4'b1000, 4'b1111, 1'b0, 4'b0000);

        // Randomized traffic.
        iv = 4'b0000;
        for (int k = 0; k < 400; k++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(3, 0) == 0) iv[b] = ~iv[b];
            ev = ($urandom_range(3, 0) == 0) ? N'($urandom) : 4'b1111;
            step(iv, ev, ($urandom_range(2, 0) == 0), N'($urandom));
        end

        // Drain the scoreboard within a bounded number of cycles.
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        check("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 4: number of interrupt sources, range 1..32.
REQ-002 Parameter GAP_CYCLES, default 2: minimum irq_o low cycles before re-assertion, range 1..15.
REQ-003 clk  input  1  sole clock, rising edge; one clock, all logic in this domain.
REQ-004 reset  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
REQ-005 irq_i  input  NUM_IRQ  level interrupt lines from sources (e.g. timer interrupt_o), synchronous to clk.
REQ-006 enable_i  input  NUM_IRQ  per-source mask, 1 = forwarded to irq_o.
REQ-007 ack_valid_i  input  1  acknowledge request from software/register block.
REQ-008 ack_mask_i  input  NUM_IRQ  write-1-to-clear pending bits; sampled when ack_valid_i and ack_ready_o are both high.
REQ-009 ack_ready_o  output  1  acknowledge accepted this cycle.
REQ-010 pending_o  output  NUM_IRQ  latched pending bits, unmasked view.
REQ-011 irq_o  output  1  aggregated registered interrupt to processor.
REQ-012 overflow_o  output  NUM_IRQ  sticky flag: new edge on an already-pending source (present only with REQ-030 macro).

Function
REQ-013 Rising edge of irq_i[n] (low in cycle t-1, high in cycle t) SHALL set pending[n] at clock edge ending cycle t; a held-high level SHALL NOT re-set a cleared bit.
REQ-014 Accepted ack SHALL clear pending[n] for each ack_mask_i[n]=1 in the following cycle.
REQ-015 Same-cycle edge and ack clear on the same bit: set SHALL win, bit stays 1.
REQ-016 ack_ready_o SHALL be 1 in every state except GAP; handshake completes on valid&&ready in one cycle; valid held during GAP SHALL be accepted on first ready cycle.
REQ-017 active = |(pending & enable_i), combinational.
REQ-018 FSM states IDLE, ASSERT, GAP; irq_o = 1 only in ASSERT.
REQ-019 IDLE -> ASSERT when active; ASSERT -> GAP when active falls to 0; GAP counts GAP_CYCLES cycles then -> ASSERT if active else IDLE.
REQ-020 Latency: edge on enabled source in IDLE SHALL raise irq_o 2 cycles after irq_i rises (pending set, then FSM).
REQ-021 Clearing enable_i while in ASSERT SHALL behave as ack: ASSERT -> GAP.
REQ-022 Edges arriving during GAP SHALL be latched in pending and cause re-assertion after GAP expires.
REQ-023 GAP counter width 4 bits; SHALL not wrap; loaded with GAP_CYCLES-1 on entry, decremented to 0.
REQ-024 Unknown FSM encoding SHALL return to IDLE next cycle.

Reset
REQ-025 On reset low: pending=0, overflow_o=0, irq_o=0, FSM=IDLE, gap counter=0, edge-detect history=0.
REQ-026 ack_ready_o SHALL read 1 immediately after reset deassertion.
REQ-027 Edge-detect history reset to 0, so a source high at reset release SHALL register as an edge on the first clock.
REQ-028 Reset asserted mid-ASSERT or mid-GAP SHALL drop irq_o within the same cycle (async) without glitch back.
REQ-029 No output SHALL depend on reset deassertion timing beyond one clk.

Configuration
REQ-030 Macro IRQ_CTRL_OVERFLOW_EN defined: overflow_o[n] sets when an edge occurs while pending[n]=1 and no same-cycle clear; cleared only by accepted ack with ack_mask_i[n]=1 (same set-wins rule).
REQ-031 Macro undefined: overflow_o port and its logic absent; all other behaviour identical.

Structure
REQ-032 Package irq_ctrl_pkg SHALL hold the FSM state enum (IDLE, ASSERT, GAP), GAP counter width constant (4) and NUM_IRQ default.
REQ-033 Sub-module irq_edge_detect (NUM_IRQ wide, registered history, outputs one-cycle rise pulses) SHALL be instantiated once.

Verification
REQ-034 Reset, irq_i[0] 0->1, enable_i=4'b0001 -> pending_o=0001 one cycle later, irq_o=1 two cycles after edge.
REQ-035 Pending 0001, ack_mask_i=0001 accepted -> pending_o=0000, irq_o low for exactly 2 cycles (GAP_CYCLES=2), ack_ready_o=0 during GAP.
REQ-036 Edge on irq_i[2] in same cycle as ack_mask_i=0100 -> pending_o[2] stays 1, irq_o re-asserts after GAP.
REQ-037 enable_i=0000, edge on irq_i[1] -> pending_o=0010, irq_o stays 0; set enable_i=0010 -> irq_o=1 next cycle.
REQ-038 With IRQ_CTRL_OVERFLOW_EN, two edges on irq_i[3] without ack -> overflow_o=1000; ack 1000 -> overflow_o=0000, pending_o[3]=0.
REQ-039 Reset pulled low while irq_o=1 in ASSERT -> irq_o=0 before next clk edge, all outputs at REQ-025 values.
